// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with a live prescaler,
// pause/resume, optional auto-reload and a one-cycle done pulse.
module down_timer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      reload_reg;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick_c;

    // Prescaler terminal: >= so a prescale lowered mid-count still ticks promptly
    always_comb begin
        tick_c = 1'b0;
        if (pre_cnt >= prescale) begin
            tick_c = 1'b1;
        end
    end

    // Control state, counters and registered outputs; priority load > stop > start > tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            pre_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                reload_reg <= load_val;
                count      <= load_val;
                pre_cnt    <= '0;
                // Loading zero into an active timer cancels it silently
                if ((load_val == '0) && (state != IDLE)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (stop) begin
                // stop shadows any simultaneous start
                if (state == RUN) begin
                    state <= PAUSED;
                end
            end else if (start && (state != RUN)) begin
                if (state == PAUSED) begin
                    // pre_cnt kept so the resumed period is exact
                    state <= RUN;
                end else if (count != '0) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    pre_cnt <= '0;
                end else begin
                    // Zero-length timeout
                    done <= 1'b1;
                end
            end else if (state == RUN) begin
                if (tick_c) begin
                    pre_cnt <= '0;
                    if (count > WIDTH'(1)) begin
                        count <= count - WIDTH'(1);
                    end else begin
                        done <= 1'b1;
                        if (auto_reload) begin
                            count <= reload_reg;
                        end else begin
                            count <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end else begin
                    pre_cnt <= pre_cnt + PRESCALE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer.
module tb_down_timer;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PRESCALE_W = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  start;
    logic                  stop;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;

    int tests;
    int fails;

    down_timer #(
        .WIDTH      (WIDTH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] exp;
        prescale = 4'd0; auto_reload = 1'b0;
        load_val = 8'd3; load = 1'b1; cyc(); load = 1'b0;
        tests++; if (count !== 8'd3) begin fails++; $display("FAIL basic_load got=%0d exp=3", count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_load_busy got=%b exp=0", busy); end
        start = 1'b1; cyc(); start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_start_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            exp = WIDTH'(3 - k);
            tests++; if (count !== exp) begin fails++; $display("FAIL basic_count k=%0d got=%0d exp=%0d", k, count, exp); end
            tests++; if (done !== (k == 3)) begin fails++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, (k == 3)); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_end_busy got=%b exp=0", busy); end
        cyc();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_prescale();
        logic [WIDTH-1:0] exp;
        prescale = 4'd3;
        load_val = 8'd2; load = 1'b1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp = WIDTH'(2 - k / 4);
            tests++; if (count !== exp) begin fails++; $display("FAIL presc_count k=%0d got=%0d exp=%0d", k, count, exp); end
            tests++; if (done !== (k == 8)) begin fails++; $display("FAIL presc_done k=%0d got=%b exp=%b", k, done, (k == 8)); end
        end
    endtask

    task automatic test_pause_resume();
        logic [WIDTH-1:0] exp;
        prescale = 4'd1;
        load_val = 8'd5; load = 1'b1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (3) cyc();
        stop = 1'b1; cyc(); stop = 1'b0;
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL pause_count got=%0d exp=4", count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pause_busy got=%b exp=1", busy); end
        repeat (10) cyc();
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL pause_frozen got=%0d exp=4", count); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL pause_done got=%b exp=0", done); end
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            exp = WIDTH'(3 - (k - 1) / 2);
            tests++; if (count !== exp) begin fails++; $display("FAIL resume_count k=%0d got=%0d exp=%0d", k, count, exp); end
            tests++; if (done !== (k == 7)) begin fails++; $display("FAIL resume_done k=%0d got=%b exp=%b", k, done, (k == 7)); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL resume_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_auto_reload();
        logic [WIDTH-1:0] exp;
        prescale = 4'd0; auto_reload = 1'b1;
        load_val = 8'd4; load = 1'b1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp = ((k % 4) == 0) ? 8'd4 : WIDTH'(4 - (k % 4));
            tests++; if (count !== exp) begin fails++; $display("FAIL auto_count k=%0d got=%0d exp=%0d", k, count, exp); end
            tests++; if (done !== ((k % 4) == 0)) begin fails++; $display("FAIL auto_done k=%0d got=%b exp=%b", k, done, ((k % 4) == 0)); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL auto_busy k=%0d got=%b exp=1", k, busy); end
        end
        auto_reload = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            exp = WIDTH'(4 - k);
            tests++; if (count !== exp) begin fails++; $display("FAIL last_count k=%0d got=%0d exp=%0d", k, count, exp); end
            tests++; if (done !== (k == 4)) begin fails++; $display("FAIL last_done k=%0d got=%b exp=%b", k, done, (k == 4)); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL last_busy got=%b exp=0", busy); end
    endtask

    task automatic test_corners();
        // Zero-length timeout from IDLE with count==0
        start = 1'b1; cyc(); start = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL zero_busy got=%b exp=0", busy); end
        cyc();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_clear got=%b exp=0", done); end

        // stop and start together while running: pause wins
        prescale = 4'd0;
        load_val = 8'd5; load = 1'b1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL ss_pre got=%0d exp=4", count); end
        stop = 1'b1; start = 1'b1; cyc(); stop = 1'b0; start = 1'b0;
        repeat (3) cyc();
        tests++; if (count !== 8'd4) begin fails++; $display("FAIL ss_frozen got=%0d exp=4", count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ss_busy got=%b exp=1", busy); end

        // Loading zero while running cancels without done
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        tests++; if (count !== 8'd3) begin fails++; $display("FAIL l0_pre got=%0d exp=3", count); end
        load_val = 8'd0; load = 1'b1; cyc(); load = 1'b0;
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL l0_count got=%0d exp=0", count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL l0_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL l0_done got=%b exp=0", done); end
        cyc();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL l0_done_next got=%b exp=0", done); end

        // Load on a tick cycle discards the tick
        load_val = 8'd6; load = 1'b1; cyc(); load = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        tests++; if (count !== 8'd5) begin fails++; $display("FAIL lt_pre got=%0d exp=5", count); end
        load_val = 8'd9; load = 1'b1; cyc(); load = 1'b0;
        tests++; if (count !== 8'd9) begin fails++; $display("FAIL lt_count got=%0d exp=9", count); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL lt_busy got=%b exp=1", busy); end
        cyc();
        tests++; if (count !== 8'd8) begin fails++; $display("FAIL lt_next got=%0d exp=8", count); end
    endtask

    task automatic test_reset_mid_run();
        prescale = 4'd15;
        load_val = 8'd7; load = 1'b1; cyc(); load = 1'b0;
        tests++; if ((count !== 8'd7) || (busy !== 1'b1)) begin fails++; $display("FAIL rm_pre count=%0d busy=%b exp=7/1", count, busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL rm_count got=%0d exp=0", count); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rm_done got=%b exp=0", done); end
        #2;
        rst_n = 1'b1;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL rm_zero_done got=%b exp=1", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_zero_busy got=%b exp=0", busy); end
        cyc();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rm_zero_clear got=%b exp=0", done); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        load = 1'b0;
        load_val = '0;
        start = 1'b0;
        stop = 1'b0;
        auto_reload = 1'b0;
        prescale = '0;
        test_reset();
        test_basic();
        test_prescale();
        test_pause_resume();
        test_auto_reload();
        test_corners();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
